// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default oversampling factor and the baud-tick divider calculation.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Rounded clk_freq / (baud * os); callers keep the result >= 2.
  function automatic int calc_tick_div(input int clk_freq, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: free-running divider that emits a 1-clk tick
// at each wrap and restarts from zero on a synchronous clear.
module uart_os_tick #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter and registered tick pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_r <= cnt_r + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rxd.sv
// UART 8N1 receiver, MSB-first, sampling the line mid-bit at OVERSAMPLE x baud.
// Delivers bytes with a 1-clk valid pulse and flags bad stop bits.
module uart_rxd
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rs232_rxd,
  output logic [7:0] o_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_rx_busy
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic            prev_r;
  logic            fall_s;
  logic            start_s;
  logic            tick_s;
  rx_state_t       state_r;
  logic [OSW-1:0]  os_cnt_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shreg_r;

  assign fall_s  = prev_r & ~sync2_r;
  assign start_s = (state_r == ST_IDLE) & fall_s;

  // Restarting the divider on the start edge fixes the sample phase per frame.
  uart_os_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_s),
    .tick (tick_s)
  );

  // Two-flop synchroniser plus history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= i_rs232_rxd;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Receive FSM with shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      os_cnt_r    <= '0;
      bit_cnt_r   <= 3'd0;
      shreg_r     <= 8'h00;
      o_data      <= 8'h00;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_rx_busy   <= 1'b0;
    end else begin
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            state_r   <= ST_START;
            os_cnt_r  <= '0;
            o_rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (os_cnt_r == OS_HALF) begin
              if (!sync2_r) begin
                state_r   <= ST_DATA;
                os_cnt_r  <= '0;
                bit_cnt_r <= 3'd0;
              end else begin
                state_r   <= ST_IDLE;
                o_rx_busy <= 1'b0;
              end
            end else begin
              os_cnt_r <= os_cnt_r + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (os_cnt_r == OS_LAST) begin
              os_cnt_r <= '0;
              shreg_r  <= {shreg_r[6:0], sync2_r};
              if (bit_cnt_r == 3'd7) begin
                state_r <= ST_STOP;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end else begin
              os_cnt_r <= os_cnt_r + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            if (os_cnt_r == OS_LAST) begin
              os_cnt_r <= '0;
              if (sync2_r) begin
                o_data     <= shreg_r;
                o_rx_valid <= 1'b1;
                state_r    <= ST_IDLE;
                o_rx_busy  <= 1'b0;
              end else begin
                o_frame_err <= 1'b1;
                state_r     <= ST_BREAK;
              end
            end else begin
              os_cnt_r <= os_cnt_r + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (sync2_r) begin
            state_r   <= ST_IDLE;
            o_rx_busy <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          o_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rxd.sv
// Randomised self-checking bench for uart_rxd: a line-level frame model
// predicts each byte / framing error and its arrival window.
module tb_uart_rxd;

  localparam int BIT = 160;           // clk per bit at 1.6 MHz / 10 kbaud
  localparam int LAT = 9 * BIT + BIT / 2 + 3;  // 9.5 bits + 2 sync + 1 output reg
  localparam int TOL = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] o_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_rx_busy;

  uart_rxd #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rs232_rxd(rxd),
    .o_data     (o_data),
    .o_rx_valid (o_rx_valid),
    .o_frame_err(o_frame_err),
    .o_rx_busy  (o_rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] model_data = 8'h00;
  int         m_state = 0;     // 0 idle, 1 in frame, 2 waiting for line high
  int         m_fall = 0;
  logic       m_prev = 1'b1;
  logic [7:0] m_byte = 8'h00;
  int         k;
  int         idx;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Line model and output comparison, one step per clock.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_state    = 0;
        m_prev     = 1'b1;
        model_data = 8'h00;
        q.delete();
      end else begin
        case (m_state)
          0: if (m_prev && !rxd) begin
               m_state = 1;
               m_fall  = cyc;
             end
          1: begin
               k = cyc - m_fall - BIT / 2;
               if (k >= 0 && (k % BIT) == 0) begin
                 idx = k / BIT;
                 if (idx == 0) begin
                   if (rxd) m_state = 0;
                 end else if (idx <= 8) begin
                   m_byte[8 - idx] = rxd;
                 end else begin
                   q.push_back('{is_err: !rxd, data: m_byte, due: m_fall + LAT});
                   m_state = rxd ? 0 : 2;
                 end
               end
             end
          2: if (rxd) m_state = 0;
          default: m_state = 0;
        endcase
        m_prev = rxd;

        check(!(o_rx_valid && o_frame_err), "pulse_exclusive", {o_rx_valid, o_frame_err}, 0);
        if (o_rx_valid || o_frame_err) begin
          valid_cnt += int'(o_rx_valid);
          err_cnt   += int'(o_frame_err);
          if (q.size() == 0) begin
            check(1'b0, "unexpected_pulse", {o_rx_valid, o_frame_err}, 0);
          end else begin
            e = q.pop_front();
            check(o_rx_valid == !e.is_err, "pulse_kind", int'(o_rx_valid), int'(!e.is_err));
            check(cyc >= e.due - TOL && cyc <= e.due + TOL, "pulse_time", cyc, e.due);
            if (!e.is_err) begin
              check(o_data == e.data, "rx_data", o_data, e.data);
              model_data = e.data;
            end else begin
              check(o_data == model_data, "data_hold_on_err", o_data, model_data);
            end
          end
        end else if (q.size() != 0 && cyc > q[0].due + TOL) begin
          check(1'b0, "missing_pulse", cyc, q[0].due);
          q.delete(0);
        end
        if ((cyc % 16) == 0) check(o_data == model_data, "data_stable", o_data, model_data);
      end
    end
  end

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bl);
    drive(1'b0, bl);
    for (int i = 7; i >= 0; i--) begin
      drive(d[i], bl);
      if (i == 7) check(o_rx_busy == 1'b1, "frame_busy", o_rx_busy, 1);
    end
    drive(stop, bl);
  endtask

  int v0;
  int e0;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check(o_data == 8'h00, "reset_data", o_data, 8'h00);
    check(o_rx_valid == 1'b0, "reset_valid", o_rx_valid, 0);
    check(o_frame_err == 1'b0, "reset_err", o_frame_err, 0);
    check(o_rx_busy == 1'b0, "reset_busy", o_rx_busy, 0);
    rst = 1'b0;
    drive(1'b1, 20);

    // Single frame 0xA5
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, BIT);
    drive(1'b1, 40);
    check(valid_cnt - v0 == 1, "t1_valid_cnt", valid_cnt - v0, 1);
    check(err_cnt == e0, "t1_err_cnt", err_cnt - e0, 0);
    check(o_data == 8'hA5, "t1_data", o_data, 8'hA5);
    check(o_rx_busy == 1'b0, "t1_idle_busy", o_rx_busy, 0);

    // Back-to-back 0x00 then 0xFF with a single stop bit
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, BIT);
    check(o_data == 8'h00, "t2_data0", o_data, 8'h00);
    send_frame(8'hFF, 1'b1, BIT);
    drive(1'b1, 40);
    check(o_data == 8'hFF, "t2_data1", o_data, 8'hFF);
    check(valid_cnt - v0 == 2, "t2_valid_cnt", valid_cnt - v0, 2);

    // 40-clk glitch: false start
    v0 = valid_cnt; e0 = err_cnt;
    drive(1'b0, 40);
    drive(1'b1, 20);
    check(o_rx_busy == 1'b1, "t3_busy_during", o_rx_busy, 1);
    drive(1'b1, 40);
    check(o_rx_busy == 1'b0, "t3_busy_after", o_rx_busy, 0);
    check(valid_cnt + err_cnt == v0 + e0, "t3_no_pulse", valid_cnt + err_cnt - v0 - e0, 0);

    // Framing error on 0x3C, line held low afterwards
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, BIT);
    drive(1'b0, BIT);
    check(err_cnt - e0 == 1, "t4_err_cnt", err_cnt - e0, 1);
    check(o_data == 8'hFF, "t4_data_hold", o_data, 8'hFF);
    check(o_rx_busy == 1'b1, "t4_busy_break", o_rx_busy, 1);
    drive(1'b0, 2 * BIT);
    check(o_rx_busy == 1'b1, "t4_busy_break2", o_rx_busy, 1);
    drive(1'b1, 20);
    check(o_rx_busy == 1'b0, "t4_busy_release", o_rx_busy, 0);
    check(err_cnt - e0 == 1 && valid_cnt == v0, "t4_pulses", err_cnt - e0, 1);

    // Reset mid-DATA of 0x55, then a clean 0x81
    v0 = valid_cnt;
    drive(1'b0, BIT);
    drive(1'b0, BIT);
    drive(1'b1, BIT / 2);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check(o_data == 8'h00, "t5_reset_data", o_data, 8'h00);
    check(o_rx_valid == 1'b0 && o_frame_err == 1'b0, "t5_reset_pulses",
          {o_rx_valid, o_frame_err}, 0);
    check(o_rx_busy == 1'b0, "t5_reset_busy", o_rx_busy, 0);
    drive(1'b1, 2 * BIT);
    check(valid_cnt == v0, "t5_no_valid", valid_cnt - v0, 0);
    send_frame(8'h81, 1'b1, BIT);
    drive(1'b1, 40);
    check(o_data == 8'h81, "t5_data", o_data, 8'h81);
    check(valid_cnt - v0 == 1, "t5_valid_cnt", valid_cnt - v0, 1);

    // Bit period skewed +3% and -3% on 0x96
    v0 = valid_cnt;
    send_frame(8'h96, 1'b1, BIT + 5);
    drive(1'b1, 40);
    check(o_data == 8'h96, "t6_data_slow", o_data, 8'h96);
    send_frame(8'h96, 1'b1, BIT - 5);
    drive(1'b1, 40);
    check(o_data == 8'h96, "t6_data_fast", o_data, 8'h96);
    check(valid_cnt - v0 == 2, "t6_valid_cnt", valid_cnt - v0, 2);

    // Random frames: data, stop bit, skew and inter-frame gap
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic       stop;
      int         bl;
      int         gap;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      bl   = BIT - 5 + $urandom_range(0, 10);
      gap  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 300);
      send_frame(d, stop, bl);
      if (!stop) begin
        drive(1'b0, $urandom_range(0, 2) * BIT + 1);
        drive(1'b1, gap + 20);
      end else if (gap != 0) begin
        drive(1'b1, gap);
      end
    end

    drive(1'b1, 300);
    check(q.size() == 0, "queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
